grf_wb_arbiter: RTL and testbench

- Write-side front end of the general register file.
- Merges two write sources onto the file's single write port (RegWrite/RD/WData):
  - single-cycle pipeline writebacks from the W stage;
  - out-of-order results from long-latency units (mult/div).
- Long-latency results are buffered in a small FIFO.
- A per-register pending scoreboard lets the decoder stall readers and writers of registers whose results are still in flight.

---
 rtl/grf_wb_arbiter.sv | 115 +++++++++++
 tb/tb_grf_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// Write-port arbiter for the general register file: pipeline writebacks take
// priority over buffered long-latency results; a pending scoreboard feeds the
// decoder's stall checks. Optional macro GRF_WB_BYPASS_EN enables a FIFO bypass.
module grf_wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PipeWrite,
  input  logic [4:0]        PipeRD,
  input  logic [DATA_W-1:0] PipeWData,
  input  logic              LongIssue,
  input  logic [4:0]        LongIssueRD,
  input  logic              LongValid,
  input  logic [4:0]        LongRD,
  input  logic [DATA_W-1:0] LongWData,
  output logic              LongReady,
  output logic              RegWrite,
  output logic [4:0]        RD,
  output logic [DATA_W-1:0] WData,
  input  logic [4:0]        ChkRS1,
  input  logic [4:0]        ChkRS2,
  input  logic [4:0]        ChkRD,
  output logic              Busy1,
  output logic              Busy2,
  output logic              BusyD,
  output logic [CNT_W-1:0]  Count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [4:0]        fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [31:0]       pending, pending_set, pending_clr;
  logic              pipe_take, long_take, push, pop, bypass;
  logic [4:0]        head_rd;
  logic [DATA_W-1:0] head_data;

  // Ready comes from the registered occupancy only; a same-cycle pop does not open a slot.
  assign LongReady = (Count != CNT_W'(FIFO_DEPTH));

  always_comb begin
    pipe_take = PipeWrite && (PipeRD != '0);
    long_take = LongValid && LongReady && (LongRD != '0);
    pop       = !pipe_take && (Count != '0);
`ifdef GRF_WB_BYPASS_EN
    bypass    = !pipe_take && (Count == '0) && long_take;
`else
    bypass    = 1'b0;
`endif
    push      = long_take && !bypass;
    head_rd   = fifo_rd[rd_ptr];
    head_data = fifo_data[rd_ptr];

    pending_clr = '0;
    if (pop)
      pending_clr[head_rd] = 1'b1;
    else if (bypass)
      pending_clr[LongRD] = 1'b1;

    pending_set = '0;
    if (LongIssue && (LongIssueRD != '0))
      pending_set[LongIssueRD] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= LongRD;
      fifo_data[wr_ptr] <= LongWData;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      pending  <= '0;
      RegWrite <= 1'b0;
      RD       <= '0;
      WData    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   Count <= Count + CNT_W'(1);
        2'b01:   Count <= Count - CNT_W'(1);
        default: Count <= Count;
      endcase

      // Clear first, then set, so an issue to the same register wins.
      pending  <= (pending & ~pending_clr) | pending_set;

      RegWrite <= pipe_take || pop || bypass;
      if (pipe_take) begin
        RD    <= PipeRD;
        WData <= PipeWData;
      end else if (pop) begin
        RD    <= head_rd;
        WData <= head_data;
      end else if (bypass) begin
        RD    <= LongRD;
        WData <= LongWData;
      end
    end
  end

  assign Busy1 = (ChkRS1 != '0) && pending[ChkRS1];
  assign Busy2 = (ChkRS2 != '0) && pending[ChkRS2];
  assign BusyD = (ChkRD  != '0) && pending[ChkRD];

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: a cycle model queues the expected
// register-file write per edge, which is popped and compared after the edge.
module tb_grf_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          Clk = 1'b0;
  logic          Reset;
  logic          PipeWrite, LongIssue, LongValid;
  logic [4:0]    PipeRD, LongIssueRD, LongRD, ChkRS1, ChkRS2, ChkRD;
  logic [31:0]   PipeWData, LongWData;
  logic          LongReady, RegWrite, Busy1, Busy2, BusyD;
  logic [4:0]    RD;
  logic [31:0]   WData;
  logic [CW-1:0] Count;

  grf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .PipeWrite(PipeWrite), .PipeRD(PipeRD), .PipeWData(PipeWData),
    .LongIssue(LongIssue), .LongIssueRD(LongIssueRD),
    .LongValid(LongValid), .LongRD(LongRD), .LongWData(LongWData),
    .LongReady(LongReady),
    .RegWrite(RegWrite), .RD(RD), .WData(WData),
    .ChkRS1(ChkRS1), .ChkRS2(ChkRS2), .ChkRD(ChkRD),
    .Busy1(Busy1), .Busy2(Busy2), .BusyD(BusyD),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    int          cnt;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  exp_t        exp_q[$];
  ent_t        mq[$];
  logic [31:0] m_pending;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  bit          last_hs;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic busy_of(input logic [4:0] r);
    return (r != 5'd0) && m_pending[r];
  endfunction

  task automatic idle_inputs();
    PipeWrite = 1'b0; PipeRD = '0; PipeWData = '0;
    LongIssue = 1'b0; LongIssueRD = '0;
    LongValid = 1'b0; LongRD = '0; LongWData = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_pending = '0;
    m_rd      = '0;
    m_wd      = '0;
  endtask

  // Called between edges with the inputs for the coming edge already driven.
  task automatic cycle();
    exp_t  e;
    ent_t  n;
    bit    pipe_take, hs, pop, byp;
    logic [31:0] clr, set;
    #1;
    check("long_ready", LongReady, mq.size() < DEPTH);
    check("busy1", Busy1, busy_of(ChkRS1));
    check("busy2", Busy2, busy_of(ChkRS2));
    check("busyd", BusyD, busy_of(ChkRD));

    pipe_take = PipeWrite && (PipeRD != 0);
    hs        = LongValid && (mq.size() < DEPTH);
    pop       = !pipe_take && (mq.size() > 0);
    byp       = 1'b0;
`ifdef GRF_WB_BYPASS_EN
    byp       = !pipe_take && (mq.size() == 0) && hs && (LongRD != 0);
`endif
    clr = '0;
    set = '0;
    if (pipe_take) begin
      m_rd = PipeRD; m_wd = PipeWData;
    end else if (pop) begin
      n = mq.pop_front();
      m_rd = n.rd; m_wd = n.wd;
      clr[n.rd] = 1'b1;
    end else if (byp) begin
      m_rd = LongRD; m_wd = LongWData;
      clr[LongRD] = 1'b1;
    end
    if (hs && (LongRD != 0) && !byp) begin
      n.rd = LongRD; n.wd = LongWData;
      mq.push_back(n);
    end
    if (LongIssue && (LongIssueRD != 0)) set[LongIssueRD] = 1'b1;
    m_pending = (m_pending & ~clr) | set;
    last_hs   = hs;

    e.we  = pipe_take || pop || byp;
    e.rd  = m_rd;
    e.wd  = m_wd;
    e.cnt = mq.size();
    exp_q.push_back(e);

    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check("reg_write", RegWrite, e.we);
    check("rd", RD, e.rd);
    check("wdata", WData, e.wd);
    check("count", Count, e.cnt);
  endtask

  initial begin
    ent_t src[5];
    int   idx;

    idle_inputs();
    ChkRS1 = '0; ChkRS2 = '0; ChkRD = '0;
    Reset = 1'b0;
    model_reset();
    #3;
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_rd", RD, 5'd0);
    check("rst_wdata", WData, 32'd0);
    check("rst_count", Count, 0);
    @(negedge Clk);
    Reset = 1'b1;
    check("rst_ready", LongReady, 1'b1);
    cycle();

    // Single pipeline write, then idle.
    PipeWrite = 1'b1; PipeRD = 5'd5; PipeWData = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    cycle();

    // Long op to $9: pending visible, then result with minimum latency.
    LongIssue = 1'b1; LongIssueRD = 5'd9; ChkRS1 = 5'd9;
    cycle();
    idle_inputs();
    cycle();
    LongValid = 1'b1; LongRD = 5'd9; LongWData = 32'h1234;
    cycle();
    idle_inputs();
    repeat (3) cycle();

    // Two buffered results starved by four pipe writes, then drained in order.
    for (int unsigned i = 0; i < 4; i++) begin
      PipeWrite = 1'b1; PipeRD = 5'(1 + i); PipeWData = 32'h100 + i;
      LongValid = (i < 2); LongRD = 5'(20 + i); LongWData = 32'hA000 + i;
      LongIssue = (i < 2); LongIssueRD = 5'(20 + i); ChkRS2 = 5'd20;
      cycle();
    end
    idle_inputs();
    repeat (3) cycle();

    // Fill to full under pipe pressure; fifth result held until a slot opens.
    for (int unsigned i = 0; i < 5; i++) begin
      src[i].rd = 5'(10 + i);
      src[i].wd = 32'hC0DE_0000 + i;
    end
    idx = 0;
    for (int unsigned i = 0; i < 20 && (idx < 5 || mq.size() > 0); i++) begin
      PipeWrite = (i < 7); PipeRD = 5'd3; PipeWData = 32'h5000 + i;
      LongValid = (idx < 5);
      LongRD    = (idx < 5) ? src[idx].rd : 5'd0;
      LongWData = (idx < 5) ? src[idx].wd : 32'd0;
      ChkRD     = 5'd14;
      cycle();
      if (last_hs && idx < 5) idx++;
    end
    check("fill_all_taken", idx, 5);
    idle_inputs();
    cycle();

    // Result to $0 is discarded; pipe write to $0 lets the FIFO head through.
    LongValid = 1'b1; LongRD = 5'd0; LongWData = 32'hBAD0;
    cycle();
    PipeWrite = 1'b1; PipeRD = 5'd7; PipeWData = 32'h77;
    LongRD = 5'd6; LongWData = 32'h66;
    cycle();
    idle_inputs();
    PipeWrite = 1'b1; PipeRD = 5'd0; PipeWData = 32'hFFFF;
    cycle();
    idle_inputs();
    cycle();

    // Random traffic over a few registers to hit set/clear collisions.
    for (int unsigned i = 0; i < 300; i++) begin
      PipeWrite   = ($urandom_range(0, 2) == 0);
      PipeRD      = 5'($urandom_range(0, 7));
      PipeWData   = $urandom;
      LongIssue   = $urandom_range(0, 1);
      LongIssueRD = 5'($urandom_range(0, 7));
      LongValid   = $urandom_range(0, 1);
      LongRD      = 5'($urandom_range(0, 7));
      LongWData   = $urandom;
      ChkRS1      = 5'($urandom_range(0, 7));
      ChkRS2      = 5'($urandom_range(0, 7));
      ChkRD       = 5'($urandom_range(0, 7));
      cycle();
    end

    // Mid-stream reset with three queued results and $8 pending.
    idle_inputs();
    repeat (DEPTH) cycle();
    LongIssue = 1'b1; LongIssueRD = 5'd8;
    cycle();
    for (int unsigned i = 0; i < 3; i++) begin
      PipeWrite = 1'b1; PipeRD = 5'd2; PipeWData = 32'h2000 + i;
      LongIssue = 1'b0;
      LongValid = 1'b1; LongRD = (i == 0) ? 5'd8 : 5'(24 + i); LongWData = 32'hE000 + i;
      cycle();
    end
    check("pre_rst_count", Count, 3);
    idle_inputs();
    ChkRS1 = 5'd8;
    #1;
    check("pre_rst_busy8", Busy1, 1'b1);
    Reset = 1'b0;
    #1;
    check("mid_rst_regwrite", RegWrite, 1'b0);
    check("mid_rst_count", Count, 0);
    check("mid_rst_busy8", Busy1, 1'b0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
